// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg
//   Shared definitions for the ALU writeback slice: ALU op encoding,
//   branch-condition encoding, buffer entry layout and occupancy states.
//   No ports (package).
package alu_writeback_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;

    // ALU op encoding as carried on IN_OP
    localparam logic [1:0] kADD = 2'd0;
    localparam logic [1:0] kSUB = 2'd1;
    localparam logic [1:0] kAND = 2'd2;
    localparam logic [1:0] kXOR = 2'd3;

    // bit0 selects the flag (0=ZERO, 1=EQUAL), bit1 inverts the result
    typedef enum logic [1:0] {
        kBR_Z  = 2'b00,
        kBR_EQ = 2'b01,
        kBR_NZ = 2'b10,
        kBR_NE = 2'b11
    } br_cond_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        kWB_EMPTY = 2'd0,
        kWB_ONE   = 2'd1,
        kWB_FULL  = 2'd2
    } wb_state_t;

    function automatic logic br_resolve(br_cond_t c, logic zero, logic equal);
        return (c[0] ? equal : zero) ^ c[1];
    endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// alu_wb_fifo
//   Two-entry result buffer with an explicit occupancy FSM.
//   Ports:
//     clk, rst       clock / async active-high reset
//     push, push_entry  enqueue one entry (ignored when full)
//     pop            dequeue head (ignored when empty)
//     head           current head entry (zero after reset)
//     head_valid     buffer holds at least one entry
//     full           buffer holds two entries
module alu_wb_fifo
    import alu_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      head_valid,
    output logic      full
);

    wb_entry_t mem [DEPTH];
    logic      rd_ptr;
    logic      wr_ptr;
    wb_state_t state;

    logic push_ok;
    logic pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & head_valid;

    // Head reads straight from storage; rd_ptr only moves on a pop,
    // so the head stays stable while the consumer stalls.
    assign head = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            state      <= kWB_EMPTY;
            head_valid <= 1'b0;
            full       <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) rd_ptr <= ~rd_ptr;

            case (state)
                kWB_EMPTY: begin
                    if (push_ok) begin
                        state      <= kWB_ONE;
                        head_valid <= 1'b1;
                    end
                end
                kWB_ONE: begin
                    // simultaneous push+pop keeps one entry
                    if (push_ok && !pop_ok) begin
                        state <= kWB_FULL;
                        full  <= 1'b1;
                    end else if (pop_ok && !push_ok) begin
                        state      <= kWB_EMPTY;
                        head_valid <= 1'b0;
                    end
                end
                kWB_FULL: begin
                    if (pop_ok) begin
                        state <= kWB_ONE;
                        full  <= 1'b0;
                    end
                end
                default: begin
                    state      <= kWB_EMPTY;
                    head_valid <= 1'b0;
                    full       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback
//   Consumer end of the ALU result interface. Buffers register-file writes
//   (two entries), keeps the architectural ZERO/EQUAL flags and resolves
//   conditional branches from the flags of the accepted op.
//   Ports:
//     CLK, RESET                  clock / async active-high reset
//     IN_VALID/IN_READY           ALU result handshake
//     IN_OP, IN_RESULT, IN_ZERO, IN_EQUAL, IN_DEST   ALU result payload
//     IN_WRITE, IN_SETFLAGS, IN_BRANCH, IN_COND      per-op actions
//     WB_VALID/WB_READY, WB_ADDR, WB_DATA            register-file write port
//     FLAG_ZERO, FLAG_EQUAL       architectural flags
//     BRANCH_TAKEN                one-cycle taken pulse
//   Optional: ALU_WB_STATS_EN adds STAT_WRITES / STAT_STALLS counters.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int W     = WB_DATA_W,
    parameter int AW    = WB_ADDR_W,
    parameter int DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [1:0]    IN_OP,
    input  logic [W-1:0]  IN_RESULT,
    input  logic          IN_ZERO,
    input  logic          IN_EQUAL,
    input  logic [AW-1:0] IN_DEST,
    input  logic          IN_WRITE,
    input  logic          IN_SETFLAGS,
    input  logic          IN_BRANCH,
    input  logic [1:0]    IN_COND,
    output logic          WB_VALID,
    input  logic          WB_READY,
    output logic [AW-1:0] WB_ADDR,
    output logic [W-1:0]  WB_DATA,
    output logic          FLAG_ZERO,
    output logic          FLAG_EQUAL,
    output logic          BRANCH_TAKEN
`ifdef ALU_WB_STATS_EN
    ,
    output logic [15:0]   STAT_WRITES,
    output logic [15:0]   STAT_STALLS
`endif
);

    logic      accept;
    logic      pop;
    logic      full;
    wb_entry_t push_entry;
    wb_entry_t head;
    br_cond_t  cond;

    // The op code travels with the result but writeback does not act on it.
    logic op_unused;
    assign op_unused = ^IN_OP;

    // Ready depends only on registered occupancy, never on WB_READY.
    assign IN_READY = ~full;
    assign accept   = IN_VALID & IN_READY;
    assign pop      = WB_VALID & WB_READY;

    assign push_entry.addr = IN_DEST;
    assign push_entry.data = IN_RESULT;
    assign cond            = br_cond_t'(IN_COND);

    alu_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RESET),
        .push       (accept & IN_WRITE),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (WB_VALID),
        .full       (full)
    );

    assign WB_ADDR = head.addr;
    assign WB_DATA = head.data;

    // Branches resolve from the incoming flags so a setflags op followed
    // by a branch in the next cycle needs no bypass.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FLAG_ZERO    <= 1'b0;
            FLAG_EQUAL   <= 1'b0;
            BRANCH_TAKEN <= 1'b0;
        end else begin
            if (accept && IN_SETFLAGS) begin
                FLAG_ZERO  <= IN_ZERO;
                FLAG_EQUAL <= IN_EQUAL;
            end
            BRANCH_TAKEN <= accept & IN_BRANCH & br_resolve(cond, IN_ZERO, IN_EQUAL);
        end
    end

`ifdef ALU_WB_STATS_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STAT_WRITES <= 16'd0;
            STAT_STALLS <= 16'd0;
        end else begin
            if (pop)                   STAT_WRITES <= STAT_WRITES + 16'd1;
            if (IN_VALID && !IN_READY) STAT_STALLS <= STAT_STALLS + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [1:0]  IN_OP = 2'd0;
    logic [15:0] IN_RESULT = 16'd0;
    logic        IN_ZERO = 1'b0;
    logic        IN_EQUAL = 1'b0;
    logic [3:0]  IN_DEST = 4'd0;
    logic        IN_WRITE = 1'b0;
    logic        IN_SETFLAGS = 1'b0;
    logic        IN_BRANCH = 1'b0;
    logic [1:0]  IN_COND = 2'd0;
    logic        WB_VALID;
    logic        WB_READY = 1'b0;
    logic [3:0]  WB_ADDR;
    logic [15:0] WB_DATA;
    logic        FLAG_ZERO;
    logic        FLAG_EQUAL;
    logic        BRANCH_TAKEN;
`ifdef ALU_WB_STATS_EN
    logic [15:0] STAT_WRITES;
    logic [15:0] STAT_STALLS;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_writeback dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_OP        (IN_OP),
        .IN_RESULT    (IN_RESULT),
        .IN_ZERO      (IN_ZERO),
        .IN_EQUAL     (IN_EQUAL),
        .IN_DEST      (IN_DEST),
        .IN_WRITE     (IN_WRITE),
        .IN_SETFLAGS  (IN_SETFLAGS),
        .IN_BRANCH    (IN_BRANCH),
        .IN_COND      (IN_COND),
        .WB_VALID     (WB_VALID),
        .WB_READY     (WB_READY),
        .WB_ADDR      (WB_ADDR),
        .WB_DATA      (WB_DATA),
        .FLAG_ZERO    (FLAG_ZERO),
        .FLAG_EQUAL   (FLAG_EQUAL),
        .BRANCH_TAKEN (BRANCH_TAKEN)
`ifdef ALU_WB_STATS_EN
        ,
        .STAT_WRITES  (STAT_WRITES),
        .STAT_STALLS  (STAT_STALLS)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // one clock edge; returns 1 time unit after it so outputs are settled
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] res,
                         input logic z, input logic e, input logic [3:0] dst,
                         input logic wr, input logic sf, input logic br, input logic [1:0] cnd);
        IN_VALID = v; IN_OP = op; IN_RESULT = res; IN_ZERO = z; IN_EQUAL = e;
        IN_DEST = dst; IN_WRITE = wr; IN_SETFLAGS = sf; IN_BRANCH = br; IN_COND = cnd;
    endtask

    task automatic idle();
        drive(1'b0, kADD, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        // ---- 1: reset state, single write with zero-latency drain
        #1;
        chk("rst_wb_valid", 32'(WB_VALID), 32'd0);
        chk("rst_wb_addr", 32'(WB_ADDR), 32'd0);
        chk("rst_wb_data", 32'(WB_DATA), 32'd0);
        chk("rst_flag_z", 32'(FLAG_ZERO), 32'd0);
        chk("rst_flag_e", 32'(FLAG_EQUAL), 32'd0);
        chk("rst_br", 32'(BRANCH_TAKEN), 32'd0);
        cyc(); cyc();
        RESET = 1'b0;
        cyc();
        chk("rst_in_ready", 32'(IN_READY), 32'd1);

        WB_READY = 1'b1;
        drive(1'b1, kADD, 16'h0008, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc();
        idle();
        chk("t1_valid", 32'(WB_VALID), 32'd1);
        chk("t1_addr", 32'(WB_ADDR), 32'd3);
        chk("t1_data", 32'(WB_DATA), 32'h0008);
        cyc();
        chk("t1_empty", 32'(WB_VALID), 32'd0);

        // ---- 2: back-to-back writes into a stalled consumer
        WB_READY = 1'b0;
        drive(1'b1, kADD, 16'h0001, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc();
        chk("t2_ready_after1", 32'(IN_READY), 32'd1);
        drive(1'b1, kADD, 16'h0002, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc();
        chk("t2_ready_after2", 32'(IN_READY), 32'd0);
        chk("t2_head1", 32'(WB_DATA), 32'h0001);
        drive(1'b1, kADD, 16'h0003, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc();
        chk("t2_full_hold_rdy", 32'(IN_READY), 32'd0);
        chk("t2_hold_data", 32'(WB_DATA), 32'h0001);
        chk("t2_hold_addr", 32'(WB_ADDR), 32'd1);
        WB_READY = 1'b1;
        cyc();
        chk("t2_head2_data", 32'(WB_DATA), 32'h0002);
        chk("t2_head2_addr", 32'(WB_ADDR), 32'd2);
        chk("t2_ready_again", 32'(IN_READY), 32'd1);
        cyc();   // 3rd write accepted while 2nd pops
        idle();
        chk("t2_head3_valid", 32'(WB_VALID), 32'd1);
        chk("t2_head3_data", 32'(WB_DATA), 32'h0003);
        chk("t2_head3_addr", 32'(WB_ADDR), 32'd4);
        cyc();
        chk("t2_drained", 32'(WB_VALID), 32'd0);

        // ---- 3: flag register
        drive(1'b1, kSUB, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0);
        cyc();
        idle();
        chk("t3_flag_z", 32'(FLAG_ZERO), 32'd1);
        chk("t3_flag_e", 32'(FLAG_EQUAL), 32'd1);
        chk("t3_nowrite", 32'(WB_VALID), 32'd0);
        drive(1'b1, kXOR, 16'h0007, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        cyc();
        idle();
        chk("t3_hold_z", 32'(FLAG_ZERO), 32'd1);
        chk("t3_hold_e", 32'(FLAG_EQUAL), 32'd1);
        drive(1'b1, kAND, 16'h0005, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0);
        cyc();
        idle();
        chk("t3_upd_z", 32'(FLAG_ZERO), 32'd0);
        chk("t3_upd_e", 32'(FLAG_EQUAL), 32'd1);

        // ---- 4: branch resolution (flags now Z=0 E=1)
        drive(1'b1, kSUB, 16'h0001, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, kBR_NE);
        cyc();
        idle();
        chk("t4_ne_taken", 32'(BRANCH_TAKEN), 32'd1);
        cyc();
        chk("t4_pulse_end", 32'(BRANCH_TAKEN), 32'd0);
        drive(1'b1, kSUB, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, kBR_NE);
        cyc();
        idle();
        chk("t4_ne_not", 32'(BRANCH_TAKEN), 32'd0);
        // incoming ZERO=1 while FLAG_ZERO=0, plus a write in the same op
        drive(1'b1, kSUB, 16'h00AA, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, kBR_Z);
        cyc();
        idle();
        chk("t4_z_taken", 32'(BRANCH_TAKEN), 32'd1);
        chk("t4_z_write_v", 32'(WB_VALID), 32'd1);
        chk("t4_z_write_d", 32'(WB_DATA), 32'h00AA);
        drive(1'b1, kSUB, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, kBR_NZ);
        cyc();
        idle();
        chk("t4_nz_not", 32'(BRANCH_TAKEN), 32'd0);
        chk("t4_drained", 32'(WB_VALID), 32'd0);

        // ---- 5: asynchronous reset with a full buffer
        WB_READY = 1'b0;
        drive(1'b1, kADD, 16'h0011, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 2'd0);
        cyc();
        drive(1'b1, kADD, 16'h0022, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 2'd0);
        cyc();
        idle();
        chk("t5_full", 32'(IN_READY), 32'd0);
        chk("t5_flags_set", 32'({FLAG_ZERO, FLAG_EQUAL}), 32'd3);
        #2;
        RESET = 1'b1;
        #1;
        chk("t5_async_valid", 32'(WB_VALID), 32'd0);
        chk("t5_async_flags", 32'({FLAG_ZERO, FLAG_EQUAL}), 32'd0);
        chk("t5_async_data", 32'(WB_DATA), 32'd0);
        RESET = 1'b0;
        cyc();
        chk("t5_ready_after", 32'(IN_READY), 32'd1);
        chk("t5_valid_after", 32'(WB_VALID), 32'd0);

`ifdef ALU_WB_STATS_EN
        // ---- 6: statistics counters
        chk("t6_rst_writes", 32'(STAT_WRITES), 32'd0);
        chk("t6_rst_stalls", 32'(STAT_STALLS), 32'd0);
        drive(1'b1, kADD, 16'h0001, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc(); cyc();                         // fills both entries
        repeat (5) cyc();                     // five stalled cycles
        idle();
        WB_READY = 1'b1;
        cyc(); cyc();                         // two pops
        drive(1'b1, kADD, 16'h0002, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc();
        idle();
        cyc();                                // third pop
        chk("t6_stalls", 32'(STAT_STALLS), 32'd5);
        chk("t6_writes", 32'(STAT_WRITES), 32'd3);
        // streaming K accepts yields K pops: 3 + 65532 = 16'hFFFF
        drive(1'b1, kADD, 16'h0003, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        repeat (65532) cyc();
        idle();
        cyc();
        chk("t6_writes_max", 32'(STAT_WRITES), 32'hFFFF);
        drive(1'b1, kADD, 16'h0004, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc();
        idle();
        cyc();
        chk("t6_writes_wrap", 32'(STAT_WRITES), 32'd0);
        chk("t6_stalls_hold", 32'(STAT_STALLS), 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
